dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter for the single-port 16-bit data memory. The CPU's load/store stage and a second master (DMA or debug loader) share one memory port through it. It provides round-robin fairness, an atomic lock for read-modify-write sequences with a watchdog, and a fully pipelined command and read-return path that sustains one transfer per cycle.

## Interface
- LOCK_MAX, 16: maximum consecutive cycles a master may hold the lock before forced release (2..255).
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- m0_req / m1_req  input  1  transfer request; held stable until granted.
- m0_we / m1_we  input  1  1 = write, 0 = read.
- m0_lock / m1_lock  input  1  request or hold the exclusive lock.
- m0_addr / m1_addr  input  16  word address.
- m0_wdata / m1_wdata  input  16  write data.
- m0_gnt / m1_gnt  output  1  combinational grant; req & gnt = handshake this cycle.
- m0_rvalid / m1_rvalid  output  1  registered single-cycle read-return strobe.
- m0_rdata / m1_rdata  output  16  read data, valid with rvalid.
- mem_en  output  1  registered memory command valid.
- mem_we  output  1  registered memory write enable.
- mem_addr  output  16  registered memory address.
- mem_wdata  output  16  registered memory write data.
- mem_rdata  input  16  memory read data, valid the cycle after mem_en & !mem_we.
- lock_err  output  1  one-cycle pulse on watchdog forced release.

## Operation
- States: ARB, LOCK0, LOCK1; reset state ARB.
- Last-served pointer `last` resets to 1, so m0 wins the first contention.
- ARB:
  - single requester is granted;
  - both requesting: grant the master != last;
  - `last` is set to the granted master.
- Granted transfer with mN_lock = 1 in ARB -> LOCKN.
- LOCKN:
  - only mN can be granted; the other master's gnt is 0;
  - returns to ARB on any cycle with mN_lock = 0, sampled regardless of req;
  - a transfer granted in that cycle still completes.
- Watchdog:
  - counter counts cycles spent in LOCKN;
  - on reaching LOCK_MAX: forced -> ARB, lock_err pulses, `last` = N so the other master wins the next contention;
  - re-lock requires lock deasserted, then reasserted with a new granted transfer.
- Handshake cycle T latches addr, wdata and we into mem_* for cycle T+1; mem_en = 1 in T+1, else 0.
- mem_addr, mem_wdata and mem_we hold their last values when mem_en = 0.
- Read tag (owner id) pipelines alongside the command. At end of T+2 the arbiter registers mem_rdata and asserts the owner's rvalid in T+3 (3-cycle read latency, in order).
- Writes produce no rvalid. Memory order equals grant order, so read-after-write to the same address returns the new data.
- rdata holds its last value when rvalid = 0.

## Timing
- Reset values:
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0;
  - m0/m1_rvalid = 0, m0/m1_rdata = 0;
  - lock_err = 0;
  - gnt outputs forced 0 while rst_n = 0;
  - state ARB, watchdog counter 0.
- Throughput is one handshake per cycle, back-to-back across masters with no bubble.
- Grant depends combinationally on req, lock and state; there is no path from gnt back into grant.
- Reset asserted mid-operation: in-flight commands and reads are discarded; no rvalid after rst_n rises until a new read is granted.
- Simultaneous lock exit and opposing request: in the exit cycle only mN may be granted; the other master is granted from the next cycle.
- Watchdog expiry and mN handshake in the same cycle: the handshake completes, then forced release.

## Test plan
- m0 write 0x1234 @ 0x0010, then m0 read @ 0x0010 next cycle -> mem_en in cycles 1 and 2; m0_rvalid in cycle 4 with rdata 0x1234.
- Both masters continuously requesting reads for 6 cycles -> gnt alternates m0, m1, m0, m1, m0, m1; rvalids return in the same order, 3 cycles after each grant.
- m1 read with lock = 1, then m1 write with lock = 0 while m0_req is held -> m0_gnt = 0 during both; m0 granted the cycle after lock drops.
- m0 holds lock for 20 cycles, LOCK_MAX = 16 -> forced release after 16 locked cycles; lock_err one-cycle pulse; pending m1 granted next.
- rst_n low for one cycle between a read grant and its return -> no rvalid; all outputs at reset values.
- Only m1 requesting, 4 writes back-to-back -> m1_gnt high 4 cycles; mem_we = 1 for 4 consecutive cycles; no rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single-port 16-bit data memory.
// Round-robin between m0 and m1, an exclusive lock for read-modify-write
// sequences guarded by a watchdog, and a pipelined command/read-return path
// sustaining one transfer per cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mN_req_i/we_i/lock_i        request, write enable, lock request (N = 0, 1)
//   mN_addr_i/wdata_i           word address and write data
//   mN_gnt_o                    combinational grant (req & gnt = handshake)
//   mN_rvalid_o/rdata_o         registered read return, 3 cycles after grant
//   mem_en_o/we_o/addr_o/wdata_o registered memory command
//   mem_rdata_i                 memory read data, one cycle after a read command
//   lock_err_o                  one-cycle pulse on watchdog forced release
//
// State table:
//   ARB   | round-robin arbitration between both masters
//   LOCK0 | m0 holds the lock, only m0 may be granted
//   LOCK1 | m1 holds the lock, only m1 may be granted
module dmem_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic        m0_lock_i,
    input  logic [15:0] m0_addr_i,
    input  logic [15:0] m0_wdata_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic        m1_lock_i,
    input  logic [15:0] m1_addr_i,
    input  logic [15:0] m1_wdata_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic [15:0] m0_rdata_o,
    output logic        m1_rvalid_o,
    output logic [15:0] m1_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    output logic        lock_err_o
);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // Watchdog is a down-counter; loading LOCK_MAX-1 on entry gives exactly
    // LOCK_MAX cycles in the locked state before terminal count.
    localparam logic [7:0] WD_LOAD = 8'(LOCK_MAX - 1);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  blk_q, blk_d;
    logic        lock_err_q, lock_err_d;

    logic        gnt0, gnt1, hs, sel;
    logic        sel_we, sel_lock;
    logic [15:0] sel_addr, sel_wdata;
    logic        owner, own_lock;

    logic        mem_en_q, mem_we_q;
    logic [15:0] mem_addr_q, mem_wdata_q;
    logic        rd1_q, tag1_q, rd2_q, tag2_q;
    logic        rv0_q, rv1_q;
    logic [15:0] rdata0_q, rdata1_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
            ST_LOCK0: gnt0 = m0_req_i;
            ST_LOCK1: gnt1 = m1_req_i;
            default: begin
                if (m0_req_i && m1_req_i) begin
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
            end
        endcase
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign hs        = gnt0 | gnt1;
    assign sel       = gnt1;
    assign sel_we    = sel ? m1_we_i    : m0_we_i;
    assign sel_lock  = sel ? m1_lock_i  : m0_lock_i;
    assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    assign owner     = (state_q == ST_LOCK1);
    assign own_lock  = owner ? m1_lock_i : m0_lock_i;

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        last_d     = last_q;
        lock_err_d = 1'b0;
        // A master blocked by a forced release is freed once it drops lock.
        blk_d      = blk_q & {m1_lock_i, m0_lock_i};
        if (hs) begin
            last_d = sel;
        end
        case (state_q)
            ST_ARB: begin
                if (hs && sel_lock && !blk_q[sel]) begin
                    state_d = sel ? ST_LOCK1 : ST_LOCK0;
                    wd_d    = WD_LOAD;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (!own_lock) begin
                    state_d = ST_ARB;
                end else if (wd_q == 8'd0) begin
                    state_d       = ST_ARB;
                    lock_err_d    = 1'b1;
                    blk_d[owner]  = 1'b1;
                    last_d        = owner;
                end else begin
                    wd_d = wd_q - 8'd1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            last_q     <= 1'b1;
            wd_q       <= 8'd0;
            blk_q      <= 2'b00;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            blk_q      <= blk_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Command stage plus a two-deep read tag pipe; the tag reaches the
    // return stage in the cycle mem_rdata_i is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rd1_q       <= 1'b0;
            tag1_q      <= 1'b0;
            rd2_q       <= 1'b0;
            tag2_q      <= 1'b0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
            rdata0_q    <= 16'h0000;
            rdata1_q    <= 16'h0000;
        end else begin
            mem_en_q <= hs;
            if (hs) begin
                mem_we_q    <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
            rd1_q  <= hs & ~sel_we;
            tag1_q <= sel;
            rd2_q  <= rd1_q;
            tag2_q <= tag1_q;
            rv0_q  <= rd2_q & ~tag2_q;
            rv1_q  <= rd2_q & tag2_q;
            if (rd2_q && !tag2_q) begin
                rdata0_q <= mem_rdata_i;
            end
            if (rd2_q && tag2_q) begin
                rdata1_q <= mem_rdata_i;
            end
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = rv0_q;
    assign m1_rvalid_o = rv1_q;
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign lock_err_o  = lock_err_q;

endmodule
